// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Raises irq when the count expires; the CPU clears it by writing CTRL.
//
// state | meaning
// IDLE  | waiting for CTRL.EN
// LOAD  | copy PRESET into COUNT
// CNT   | decrement COUNT toward zero
// INT   | terminal count reached; one-shot drops EN, auto-reload ends the pulse
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;

  logic        ctrl_en;
  logic [1:0]  ctrl_mode;
  logic        ctrl_im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic        hit;
  logic [1:0]  offset;
  logic        wr_hit;
  logic        ctrl_wr;
  logic        ctrl_wr_lane0;
  logic        preset_wr;
  logic        auto_reload;

  logic        load_count;
  logic        dec_count;
  logic        set_flag;
  logic        hw_clr_flag;
  logic        hw_clr_en;

  logic        unused_addr_bits;

  assign hit           = (addr[31:4] == BASE_ADDR[31:4]);
  assign offset        = addr[3:2];
  assign wr_hit        = we & hit & (|byteen);
  assign ctrl_wr       = wr_hit & (offset == 2'd0);
  assign ctrl_wr_lane0 = ctrl_wr & byteen[0];
  assign preset_wr     = wr_hit & (offset == 2'd1);
  assign auto_reload   = (ctrl_mode == 2'b01);
  assign unused_addr_bits = &{1'b0, addr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    load_count  = 1'b0;
    dec_count   = 1'b0;
    set_flag    = 1'b0;
    hw_clr_flag = 1'b0;
    hw_clr_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl_en) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        load_count  = 1'b1;
        hw_clr_flag = auto_reload;
        next_state  = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_en) begin
          next_state = ST_IDLE;
        end else if (count == 32'd0) begin
          set_flag   = 1'b1;
          next_state = ST_INT;
        end else begin
          dec_count = 1'b1;
        end
      end
      ST_INT: begin
        if (auto_reload) begin
          hw_clr_flag = 1'b1;
        end else begin
          hw_clr_en = 1'b1;
        end
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // A CPU write to CTRL lane 0 overrides the hardware EN clear on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'b00;
      ctrl_im   <= 1'b0;
    end else if (ctrl_wr_lane0) begin
      ctrl_en   <= wdata[0];
      ctrl_mode <= wdata[2:1];
      ctrl_im   <= wdata[3];
    end else if (hw_clr_en) begin
      ctrl_en   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      preset <= 32'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (preset_wr && byteen[i]) preset[8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 32'd0;
    end else if (load_count) begin
      count <= preset;
    end else if (dec_count) begin
      count <= count - 32'd1;
    end
  end

  // A terminal-count set is never lost to a coincident CTRL write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_flag <= 1'b0;
    end else if (set_flag) begin
      irq_flag <= 1'b1;
    end else if (ctrl_wr || hw_clr_flag) begin
      irq_flag <= 1'b0;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (offset)
        2'd0:    rdata = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
        2'd1:    rdata = preset;
        2'd2:    rdata = count;
        default: rdata = 32'd0;
      endcase
    end
  end

  assign irq = irq_flag & ctrl_im;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: a timeline-based reference model
// compared every cycle, plus directed literal checks.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        we = 1'b0;
  logic [3:0]  byteen = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  int total = 0;
  int bad = 0;
  bit cmp_on = 1'b0;

  timer_counter #(.BASE_ADDR(32'h0000_7F00)) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .we(we),
    .byteen(byteen),
    .wdata(wdata),
    .rdata(rdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Model: m_t is the number of edges since a run began.
  // 0 = not running, 1 = load edge pending, 2..mp+2 = counting, mp+3 = expired.
  logic              m_en = 1'b0;
  logic [1:0]        m_mode = 2'b00;
  logic              m_im = 1'b0;
  logic [31:0]       m_preset = 32'd0;
  logic              m_flag = 1'b0;
  logic [31:0]       m_hold = 32'd0;
  longint unsigned   m_t = 0;
  longint unsigned   mp = 0;

  function automatic logic [31:0] m_count_now();
    longint unsigned d;
    if (m_t >= 2) begin
      d = m_t - 2;
      if (d > mp) d = mp;
      return 32'(mp - d);
    end
    return m_hold;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] a);
    if (a[31:4] != 28'h0000_7F0) return 32'd0;
    case (a[3:2])
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count_now();
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_en = 1'b0; m_mode = 2'b00; m_im = 1'b0; m_preset = 32'd0;
      m_flag = 1'b0; m_hold = 32'd0; m_t = 0; mp = 0;
    end else begin
      logic hitw, wr_ctrl, wr_c0, auto_m, set_f, clr_hw, clr_en;
      hitw    = we && (addr[31:4] == 28'h0000_7F0) && (byteen != 4'd0);
      wr_ctrl = hitw && (addr[3:2] == 2'd0);
      wr_c0   = wr_ctrl && byteen[0];
      auto_m  = (m_mode == 2'b01);
      set_f = 1'b0; clr_hw = 1'b0; clr_en = 1'b0;
      if (m_t == 0) begin
        if (m_en) m_t = 1;
      end else if (m_t == 1) begin
        mp = {32'd0, m_preset};
        m_t = 2;
        clr_hw = auto_m;
      end else if (m_t < mp + 3) begin
        if (!m_en) begin
          m_hold = m_count_now();
          m_t = 0;
        end else begin
          m_t = m_t + 1;
          if (m_t == mp + 3) set_f = 1'b1;
        end
      end else begin
        if (auto_m) clr_hw = 1'b1; else clr_en = 1'b1;
        m_hold = 32'd0;
        m_t = 0;
      end
      if (clr_en) m_en = 1'b0;
      if (wr_c0) {m_im, m_mode, m_en} = wdata[3:0];
      if (hitw && addr[3:2] == 2'd1)
        for (int i = 0; i < 4; i++)
          if (byteen[i]) m_preset[8*i +: 8] = wdata[8*i +: 8];
      if (set_f) m_flag = 1'b1;
      else if (wr_ctrl || clr_hw) m_flag = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_on) begin
      total++;
      if (rdata !== m_rdata(addr)) begin
        bad++;
        $display("FAIL cyc_rdata addr=%h got=%h want=%h t=%0t", addr, rdata, m_rdata(addr), $time);
      end
      total++;
      if (irq !== (m_flag & m_im)) begin
        bad++;
        $display("FAIL cyc_irq got=%b want=%b t=%0t", irq, m_flag & m_im, $time);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    addr = a; wdata = d; byteen = be; we = 1'b1;
    @(negedge clk);
    we = 1'b0; byteen = 4'd0;
  endtask

  task automatic after_edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic peek(input logic [31:0] a, input string nm, input logic [31:0] exp);
    addr = a;
    #1;
    chk(nm, rdata, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cmp_on = 1'b1;

    // reset in the middle of a run
    wr(32'h7F04, 32'd100, 4'hF);
    wr(32'h7F00, 32'h1, 4'hF);
    after_edges(5);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("irq_in_reset", {31'd0, irq}, 32'd0);
    peek(32'h7F08, "count_in_reset", 32'd0);
    @(negedge clk);
    reset = 1'b1;
    after_edges(3);
    peek(32'h7F00, "rst_ctrl", 32'd0);
    peek(32'h7F04, "rst_preset", 32'd0);
    peek(32'h7F08, "rst_count", 32'd0);
    peek(32'h7F0C, "rst_rsvd", 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    wr(32'h7F04, 32'h1234_5678, 4'b0011);
    peek(32'h7F04, "preset_partial", 32'h0000_5678);

    // one-shot, P=3
    wr(32'h7F04, 32'd3, 4'hF);
    wr(32'h7F00, 32'h9, 4'hF);
    addr = 32'h7F08;
    after_edges(2); chk("os_cnt_k2", rdata, 32'd3);
    after_edges(1); chk("os_cnt_k3", rdata, 32'd2);
    after_edges(1); chk("os_cnt_k4", rdata, 32'd1);
    after_edges(1); chk("os_cnt_k5", rdata, 32'd0);
    chk("os_irq_k5", {31'd0, irq}, 32'd0);
    after_edges(1); chk("os_irq_k6", {31'd0, irq}, 32'd1);
    after_edges(2); chk("os_irq_k8", {31'd0, irq}, 32'd1);
    peek(32'h7F00, "os_ctrl_after", 32'h8);
    wr(32'h7F00, 32'h0, 4'hF);
    chk("os_irq_cleared", {31'd0, irq}, 32'd0);

    // auto-reload, P=2
    wr(32'h7F04, 32'd2, 4'hF);
    wr(32'h7F00, 32'hB, 4'hF);
    addr = 32'h7F08;
    after_edges(4); chk("ar_irq_k4", {31'd0, irq}, 32'd0);
    after_edges(1); chk("ar_irq_k5", {31'd0, irq}, 32'd1);
    after_edges(1); chk("ar_irq_k6", {31'd0, irq}, 32'd0);
    after_edges(2); chk("ar_cnt_k8", rdata, 32'd2);
    after_edges(3); chk("ar_irq_k11", {31'd0, irq}, 32'd1);
    after_edges(1); chk("ar_irq_k12", {31'd0, irq}, 32'd0);
    after_edges(5); chk("ar_irq_k17", {31'd0, irq}, 32'd1);
    wr(32'h7F00, 32'h0, 4'hF);
    after_edges(6);

    // masked interrupt, P=1
    wr(32'h7F04, 32'd1, 4'hF);
    wr(32'h7F00, 32'h1, 4'hF);
    after_edges(4); chk("mask_irq_k4", {31'd0, irq}, 32'd0);
    after_edges(2);
    peek(32'h7F00, "mask_ctrl_k6", 32'h0);
    wr(32'h7F00, 32'h8, 4'b0001);
    chk("mask_irq_after_wr", {31'd0, irq}, 32'd0);
    after_edges(2);
    chk("mask_irq_later", {31'd0, irq}, 32'd0);
    peek(32'h7F00, "mask_ctrl", 32'h8);
    wr(32'h7F00, 32'h0, 4'hF);

    // PRESET=0, plus CPU write coinciding with the hardware EN clear
    wr(32'h7F04, 32'd0, 4'hF);
    wr(32'h7F00, 32'h9, 4'hF);
    after_edges(2); chk("p0_irq_k2", {31'd0, irq}, 32'd0);
    after_edges(1); chk("p0_irq_k3", {31'd0, irq}, 32'd1);
    wr(32'h7F00, 32'h9, 4'hF);
    peek(32'h7F00, "collide_ctrl", 32'h9);
    chk("collide_irq", {31'd0, irq}, 32'd0);
    after_edges(4);
    wr(32'h7F00, 32'h0, 4'hF);
    after_edges(4);

    // MODE=10 behaves as one-shot
    wr(32'h7F00, 32'hD, 4'hF);
    after_edges(3); chk("m10_irq_k3", {31'd0, irq}, 32'd1);
    after_edges(2);
    peek(32'h7F00, "m10_ctrl", 32'hC);
    chk("m10_irq_held", {31'd0, irq}, 32'd1);
    wr(32'h7F00, 32'h0, 4'hF);
    after_edges(2);

    // stop at COUNT=5
    wr(32'h7F04, 32'd10, 4'hF);
    wr(32'h7F00, 32'h1, 4'hF);
    addr = 32'h7F08;
    after_edges(6); chk("stop_cnt_k6", rdata, 32'd6);
    wr(32'h7F00, 32'h0, 4'hF);
    addr = 32'h7F08;
    after_edges(3); chk("stop_cnt_frozen", rdata, 32'd5);

    // read-only / reserved / out-of-window writes
    wr(32'h7F08, 32'hFFFF_FFFF, 4'hF);
    wr(32'h7F0C, 32'hFFFF_FFFF, 4'hF);
    peek(32'h7F08, "ro_count", 32'd5);
    peek(32'h7F0C, "ro_rsvd", 32'd0);
    wr(32'h7F10, 32'h0000_000F, 4'hF);
    wr(32'h7F14, 32'h0000_00FF, 4'hF);
    peek(32'h7F10, "miss_rdata", 32'd0);
    after_edges(3);
    peek(32'h7F00, "miss_ctrl", 32'h0);
    peek(32'h7F04, "miss_preset", 32'd10);
    peek(32'h7F08, "miss_count", 32'd5);

    after_edges(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped timer/counter peripheral, placed downstream of the pipelined CPU core on the data bus.
- The system bridge routes the core's M-stage data port here: address, write data, byte enables and write strobe in; read data back.
- It counts down from a programmed preset and raises an interrupt request line toward the CPU's exception logic.
- Two modes: one-shot (held interrupt) and auto-reload (periodic one-cycle interrupt pulse).

Parameters:
BASE_ADDR, 32'h0000_7F00, word-aligned base of the 16-byte register window; decode compares addr[31:4] with BASE_ADDR[31:4].

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
addr  input  32  byte address from the CPU data port (same cycle as we/wdata)
we  input  1  write strobe; qualified by an address hit and byteen
byteen  input  4  byte-lane write enables; bit i enables wdata[8i+7:8i]
wdata  input  32  write data
rdata  output  32  combinational read data for addr (0 on a miss)
irq  output  1  interrupt request = irq_flag & CTRL.IM

Behaviour:
- Register map (offset = addr[3:2]):
  - 0 CTRL (R/W): [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM; bits [31:4] read 0 and ignore writes.
  - 1 PRESET (R/W, 32 bit).
  - 2 COUNT (RO; writes ignored).
  - 3 reserved: reads 0, writes ignored.
- Writes:
  - Occur at the rising edge when we=1, address hits, and the matching byteen bit is 1.
  - Partial-byte writes update only the enabled lanes. byteen=0 means no write.
- Reads:
  - rdata is purely combinational from the current register values.
  - rdata is 0 when addr misses the window.
- Reset (reset=0, asynchronous): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, so irq=0 and rdata reflects zeros.
- FSM, evaluated each rising edge:
  - IDLE: if EN=1 then LOAD, else stay. COUNT holds.
  - LOAD: COUNT<=PRESET; go to CNT. If MODE=01, clear irq_flag.
  - CNT:
    - If EN=0: go to IDLE; COUNT holds its value.
    - Else if COUNT==0: go to INT, irq_flag<=1.
    - Else: COUNT<=COUNT-1.
  - INT:
    - MODE=00: hardware clears CTRL.EN; irq_flag stays 1; go to IDLE.
    - MODE=01: irq_flag<=0 at the next edge, giving a one-cycle pulse; EN is kept; go to IDLE.
- irq_flag clearing:
  - Any CPU write hitting CTRL (any byteen) clears irq_flag.
  - No other event clears it, except as stated for MODE=01.
- Timing, with the CTRL write (EN=1) at edge k and state IDLE:
  - LOAD at k+1.
  - CNT with COUNT=P at k+2.
  - COUNT=0 at k+2+P.
  - INT and irq_flag=1 at k+3+P.
  - Auto-reload period between irq pulses is P+4 cycles.
- Boundary conditions:
  - PRESET=0: LOAD, then CNT with COUNT=0, then INT one edge later.
  - PRESET=32'hFFFF_FFFF: no overflow handling needed; COUNT only decrements and never wraps below 0.
  - A PRESET write while counting does not affect COUNT until the next LOAD.
  - A CTRL write in the same edge as the hardware clear of EN in INT: the CPU write wins, and the written EN value is kept.
  - MODE changed mid-count takes effect at the next INT.
  - IM=0 masks irq only; irq_flag still sets and is visible when IM is later set.
  - Asynchronous reset mid-count immediately returns all state to reset values; counting does not resume on release.

Test Plan:
- Reset and readback:
  - Assert reset=0 mid-operation, then release. Reads at 0x7F00/04/08/0C return 0 and irq=0.
  - Write PRESET=32'h1234_5678 with byteen=4'b0011: PRESET reads 32'h0000_5678.
- One-shot:
  - Write PRESET=3, then write CTRL=32'h9 (EN, IM, MODE 00) at edge k.
  - COUNT reads 3,2,1,0 at edges k+2..k+5.
  - irq=1 from edge k+6 and stays high; CTRL reads 32'h8.
  - A CTRL write of 0 drops irq at the next edge.
- Auto-reload:
  - PRESET=2, CTRL=32'hB.
  - irq is a one-cycle pulse at k+5, then every 6 cycles (k+11, k+17).
  - COUNT reloads to 2 each period.
- Masking:
  - PRESET=1, CTRL=32'h1 (IM=0): irq stays 0.
  - After INT, write byte lane 0 only with CTRL=32'h8: the flag is cleared by the CTRL write, so irq stays 0. This confirms that a CTRL write clears the flag.
- Stop and edge cases:
  - Write CTRL.EN=0 while COUNT=5: COUNT freezes at 5 and state returns to IDLE.
  - PRESET=0 with EN=1: irq at k+3.
  - Write to COUNT or offset 0xC: no register change.
  - Address 0x7F10: rdata=0 and no write occurs.
